// File: rtl/axi_mem_arbiter_if.sv
// AXI4 bundle shared by the L2 miss path, the DMA/debug engine and the SRAM slave.
// Carries the five AXI4 channels without IDs; widths are set per instance.
interface axi4_interface #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // write address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [LEN_WIDTH-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  // write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  // write response channel
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // read address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  // read data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  // requester side: drives addresses, write data and response readies
  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  // responder side: mirror image of master
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter: master 0 is the L2 miss path, master 1
// the DMA/debug engine, the slave is the on-chip SRAM. Whole transactions are
// granted (address phase through final response) and the owner's channels are
// muxed combinationally onto the slave, so there is no added latency and one
// IDLE cycle separates consecutive transactions.
// Build option: define AXI_ARB_FIXED_PRIORITY_EN to make master 0 win every tie
// instead of round-robin.
module axi_mem_arbiter #(
  parameter int unsigned BURST_LEN_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  axi4_interface.slave  m0_bus,
  axi4_interface.slave  m1_bus,
  axi4_interface.master s_bus,
  output logic         grant_id,
  output logic         busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ       = 2'd1;
  localparam logic [1:0] WRITE_DATA = 2'd2;
  localparam logic [1:0] WRITE_RESP = 2'd3;

  logic [1:0]                 state, state_nxt;
  logic                       grant, grant_nxt;
  logic                       last_grant;
  logic [BURST_LEN_WIDTH-1:0] beats_left, beats_left_nxt;

  logic m0_req, m1_req, any_req;
  logic winner;
  logic win_write;
  logic sel;
  logic [BURST_LEN_WIDTH-1:0] win_len;

  // arbitration: who would own the slave if the address phase completed now
  always_comb begin
    m0_req  = m0_bus.awvalid | m0_bus.arvalid;
    m1_req  = m1_bus.awvalid | m1_bus.arvalid;
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
`ifdef AXI_ARB_FIXED_PRIORITY_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end else begin
      winner = m1_req;
    end
    // a master raising both address valids gets its write served first
    win_write = winner ? m1_bus.awvalid : m0_bus.awvalid;
    if (winner) begin
      win_len = win_write ? BURST_LEN_WIDTH'(m1_bus.awlen) : BURST_LEN_WIDTH'(m1_bus.arlen);
    end else begin
      win_len = win_write ? BURST_LEN_WIDTH'(m0_bus.awlen) : BURST_LEN_WIDTH'(m0_bus.arlen);
    end
    sel = (state == IDLE) ? winner : grant;
  end

  // next-state and transaction bookkeeping
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    beats_left_nxt = beats_left;
    case (state)
      IDLE: begin
        if (any_req && win_write && s_bus.awready) begin
          state_nxt      = WRITE_DATA;
          grant_nxt      = winner;
          beats_left_nxt = win_len;
        end else if (any_req && !win_write && s_bus.arready) begin
          state_nxt      = READ;
          grant_nxt      = winner;
          beats_left_nxt = win_len;
        end
      end
      READ: begin
        if (s_bus.rvalid && (grant ? m1_bus.rready : m0_bus.rready)) begin
          if (beats_left == '0) begin
            state_nxt = IDLE;
          end else begin
            beats_left_nxt = beats_left - BURST_LEN_WIDTH'(1);
          end
        end
      end
      WRITE_DATA: begin
        if (s_bus.wready && (grant ? m1_bus.wvalid : m0_bus.wvalid)) begin
          if (beats_left == '0) begin
            state_nxt = WRITE_RESP;
          end else begin
            beats_left_nxt = beats_left - BURST_LEN_WIDTH'(1);
          end
        end
      end
      WRITE_RESP: begin
        if (s_bus.bvalid && (grant ? m1_bus.bready : m0_bus.bready)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      beats_left <= beats_left_nxt;
    end
  end

`ifdef AXI_ARB_FIXED_PRIORITY_EN
  assign last_grant = 1'b0;
`else
  // round-robin memory; reset to 1 so master 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_grant <= winner;
    end
  end
`endif

  // status outputs
  always_comb begin
    busy     = (state != IDLE);
    grant_id = grant;
  end

  // channel muxing; valids/readies only reach the owner, everything is 0 in reset
  always_comb begin
    s_bus.awaddr   = '0;
    s_bus.awlen    = '0;
    s_bus.awsize   = '0;
    s_bus.awburst  = '0;
    s_bus.awvalid  = 1'b0;
    s_bus.wdata    = '0;
    s_bus.wstrb    = '0;
    s_bus.wlast    = 1'b0;
    s_bus.wvalid   = 1'b0;
    s_bus.bready   = 1'b0;
    s_bus.araddr   = '0;
    s_bus.arlen    = '0;
    s_bus.arsize   = '0;
    s_bus.arburst  = '0;
    s_bus.arvalid  = 1'b0;
    s_bus.rready   = 1'b0;
    m0_bus.awready = 1'b0;
    m0_bus.wready  = 1'b0;
    m0_bus.bresp   = '0;
    m0_bus.bvalid  = 1'b0;
    m0_bus.arready = 1'b0;
    m0_bus.rdata   = '0;
    m0_bus.rresp   = '0;
    m0_bus.rlast   = 1'b0;
    m0_bus.rvalid  = 1'b0;
    m1_bus.awready = 1'b0;
    m1_bus.wready  = 1'b0;
    m1_bus.bresp   = '0;
    m1_bus.bvalid  = 1'b0;
    m1_bus.arready = 1'b0;
    m1_bus.rdata   = '0;
    m1_bus.rresp   = '0;
    m1_bus.rlast   = 1'b0;
    m1_bus.rvalid  = 1'b0;
    if (!reset) begin
      s_bus.awaddr  = sel ? m1_bus.awaddr  : m0_bus.awaddr;
      s_bus.awlen   = sel ? m1_bus.awlen   : m0_bus.awlen;
      s_bus.awsize  = sel ? m1_bus.awsize  : m0_bus.awsize;
      s_bus.awburst = sel ? m1_bus.awburst : m0_bus.awburst;
      s_bus.araddr  = sel ? m1_bus.araddr  : m0_bus.araddr;
      s_bus.arlen   = sel ? m1_bus.arlen   : m0_bus.arlen;
      s_bus.arsize  = sel ? m1_bus.arsize  : m0_bus.arsize;
      s_bus.arburst = sel ? m1_bus.arburst : m0_bus.arburst;
      s_bus.wdata   = sel ? m1_bus.wdata   : m0_bus.wdata;
      s_bus.wstrb   = sel ? m1_bus.wstrb   : m0_bus.wstrb;
      s_bus.wlast   = sel ? m1_bus.wlast   : m0_bus.wlast;
      m0_bus.bresp  = s_bus.bresp;
      m0_bus.rdata  = s_bus.rdata;
      m0_bus.rresp  = s_bus.rresp;
      m0_bus.rlast  = s_bus.rlast;
      m1_bus.bresp  = s_bus.bresp;
      m1_bus.rdata  = s_bus.rdata;
      m1_bus.rresp  = s_bus.rresp;
      m1_bus.rlast  = s_bus.rlast;
      case (state)
        IDLE: begin
          if (any_req) begin
            if (win_write) begin
              s_bus.awvalid = 1'b1;
              if (sel) m1_bus.awready = s_bus.awready;
              else     m0_bus.awready = s_bus.awready;
            end else begin
              s_bus.arvalid = 1'b1;
              if (sel) m1_bus.arready = s_bus.arready;
              else     m0_bus.arready = s_bus.arready;
            end
          end
        end
        READ: begin
          if (sel) begin
            m1_bus.rvalid = s_bus.rvalid;
            s_bus.rready  = m1_bus.rready;
          end else begin
            m0_bus.rvalid = s_bus.rvalid;
            s_bus.rready  = m0_bus.rready;
          end
        end
        WRITE_DATA: begin
          if (sel) begin
            s_bus.wvalid  = m1_bus.wvalid;
            m1_bus.wready = s_bus.wready;
          end else begin
            s_bus.wvalid  = m0_bus.wvalid;
            m0_bus.wready = s_bus.wready;
          end
        end
        WRITE_RESP: begin
          if (sel) begin
            m1_bus.bvalid = s_bus.bvalid;
            s_bus.bready  = m1_bus.bready;
          end else begin
            m0_bus.bvalid = s_bus.bvalid;
            s_bus.bready  = m0_bus.bready;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: reads, round-robin ties, write bursts,
// write-before-read ordering, blocking of a second master and reset mid-burst.
module tb_axi_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic grant_id;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  axi4_interface m0_if ();
  axi4_interface m1_if ();
  axi4_interface s_if ();

  axi_mem_arbiter #(.BURST_LEN_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_bus   (m0_if),
    .m1_bus   (m1_if),
    .s_bus    (s_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = 3'd2; m0_if.awburst = 2'd1; m0_if.awvalid = 1'b0;
    m0_if.wdata = '0; m0_if.wstrb = 4'hF; m0_if.wlast = 1'b0; m0_if.wvalid = 1'b0; m0_if.bready = 1'b0;
    m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.arvalid = 1'b0;
    m0_if.rready = 1'b0;
    m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = 3'd2; m1_if.awburst = 2'd1; m1_if.awvalid = 1'b0;
    m1_if.wdata = '0; m1_if.wstrb = 4'hF; m1_if.wlast = 1'b0; m1_if.wvalid = 1'b0; m1_if.bready = 1'b0;
    m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = 3'd2; m1_if.arburst = 2'd1; m1_if.arvalid = 1'b0;
    m1_if.rready = 1'b0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bresp = 2'd0; s_if.bvalid = 1'b0;
    s_if.arready = 1'b0; s_if.rdata = '0; s_if.rresp = 2'd0; s_if.rlast = 1'b0; s_if.rvalid = 1'b0;

    // reset state
    m0_if.arvalid = 1'b1;
    s_if.arready  = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_s_arvalid", 32'(s_if.arvalid), 32'd0);
    chk("rst_m0_arready", 32'(m0_if.arready), 32'd0);
    m0_if.arvalid = 1'b0;
    reset = 1'b0;
    tick();

    // m0 4-beat read
    s_if.rvalid = 1'b1; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    m0_if.araddr = 32'h100; m0_if.arlen = 8'd3; m0_if.arvalid = 1'b1;
    #1;
    chk("rd_s_araddr", s_if.araddr, 32'h100);
    chk("rd_s_arvalid", 32'(s_if.arvalid), 32'd1);
    chk("rd_m0_arready", 32'(m0_if.arready), 32'd1);
    chk("rd_m1_arready", 32'(m1_if.arready), 32'd0);
    tick();
    m0_if.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.rdata = 32'hA0 + 32'(i);
      #1;
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_grant", 32'(grant_id), 32'd0);
      chk("rd_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
      chk("rd_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
      chk("rd_m0_rdata", m0_if.rdata, 32'hA0 + 32'(i));
      tick();
    end
    chk("rd_done_busy", 32'(busy), 32'd0);

    // simultaneous reads from a fresh reset: alternate owners while both keep requesting
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m0_if.araddr = 32'h0300; m0_if.arlen = 8'd0; m0_if.arvalid = 1'b1;
    m1_if.araddr = 32'h0400; m1_if.arlen = 8'd0; m1_if.arvalid = 1'b1;
    #1;
    chk("tie_first_araddr", s_if.araddr, 32'h0300);
    chk("tie_m1_arready", 32'(m1_if.arready), 32'd0);
    tick();
    chk("tie_first_grant", 32'(grant_id), 32'd0);
    chk("tie_wait_m1_arready", 32'(m1_if.arready), 32'd0);
    tick();
    chk("tie_idle_busy", 32'(busy), 32'd0);
`ifdef AXI_ARB_FIXED_PRIORITY_EN
    chk("tie_second_araddr", s_if.araddr, 32'h0300);
    tick();
    chk("tie_second_grant", 32'(grant_id), 32'd0);
    tick();
    tick();
    chk("tie_third_grant", 32'(grant_id), 32'd0);
`else
    chk("tie_second_araddr", s_if.araddr, 32'h0400);
    chk("tie_second_m1_arready", 32'(m1_if.arready), 32'd1);
    tick();
    chk("tie_second_grant", 32'(grant_id), 32'd1);
    chk("tie_second_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    tick();
    tick();
    chk("tie_third_grant", 32'(grant_id), 32'd0);
`endif
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
    tick();
    s_if.rvalid = 1'b0;
    tick();

    // m1 8-beat write with wvalid on every other cycle
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    m1_if.awaddr = 32'h2000; m1_if.awlen = 8'd7; m1_if.awvalid = 1'b1;
    #1;
    chk("wr_s_awvalid", 32'(s_if.awvalid), 32'd1);
    chk("wr_s_awaddr", s_if.awaddr, 32'h2000);
    chk("wr_m1_awready", 32'(m1_if.awready), 32'd1);
    chk("wr_m0_awready", 32'(m0_if.awready), 32'd0);
    tick();
    m1_if.awvalid = 1'b0;
    beats = 0;
    for (int c = 0; c < 15; c++) begin
      m1_if.wvalid = (c % 2 == 0);
      m1_if.wdata  = 32'h5000 + 32'(c);
      m1_if.wlast  = (c == 14);
      #1;
      chk("wr_m1_wready", 32'(m1_if.wready), 32'd1);
      chk("wr_m0_wready", 32'(m0_if.wready), 32'd0);
      chk("wr_s_wvalid", 32'(s_if.wvalid), 32'(m1_if.wvalid));
      if (s_if.wvalid && s_if.wready) beats++;
      tick();
    end
    chk("wr_beats", 32'(beats), 32'd8);
    m1_if.wvalid = 1'b1;
    #1;
    chk("wr_resp_no_wvalid", 32'(s_if.wvalid), 32'd0);
    chk("wr_resp_m1_wready", 32'(m1_if.wready), 32'd0);
    m1_if.wvalid = 1'b0;
    s_if.bvalid = 1'b1; s_if.bresp = 2'd2; m1_if.bready = 1'b1; m0_if.bready = 1'b1;
    #1;
    chk("wr_m1_bvalid", 32'(m1_if.bvalid), 32'd1);
    chk("wr_m1_bresp", 32'(m1_if.bresp), 32'd2);
    chk("wr_m0_bvalid", 32'(m0_if.bvalid), 32'd0);
    chk("wr_s_bready", 32'(s_if.bready), 32'd1);
    tick();
    chk("wr_done_busy", 32'(busy), 32'd0);
    s_if.bvalid = 1'b0; s_if.bresp = 2'd0;

    // m0 raises awvalid and arvalid together: write first, read after the response
    s_if.arready = 1'b1; s_if.rvalid = 1'b1;
    m0_if.awaddr = 32'h0600; m0_if.awlen = 8'd0; m0_if.awvalid = 1'b1;
    m0_if.araddr = 32'h0700; m0_if.arlen = 8'd0; m0_if.arvalid = 1'b1;
    #1;
    chk("wa_s_awvalid", 32'(s_if.awvalid), 32'd1);
    chk("wa_s_arvalid", 32'(s_if.arvalid), 32'd0);
    chk("wa_m0_arready", 32'(m0_if.arready), 32'd0);
    tick();
    m0_if.awvalid = 1'b0;
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b1;
    #1;
    chk("wa_data_arready", 32'(m0_if.arready), 32'd0);
    chk("wa_data_s_arvalid", 32'(s_if.arvalid), 32'd0);
    tick();
    m0_if.wvalid = 1'b0;
    s_if.bvalid = 1'b1;
    #1;
    chk("wa_resp_arready", 32'(m0_if.arready), 32'd0);
    chk("wa_resp_m0_bvalid", 32'(m0_if.bvalid), 32'd1);
    tick();
    s_if.bvalid = 1'b0;
    #1;
    chk("wa_read_s_arvalid", 32'(s_if.arvalid), 32'd1);
    chk("wa_read_araddr", s_if.araddr, 32'h0700);
    chk("wa_read_m0_arready", 32'(m0_if.arready), 32'd1);
    tick();
    m0_if.arvalid = 1'b0;
    chk("wa_read_busy", 32'(busy), 32'd1);
    chk("wa_read_rvalid", 32'(m0_if.rvalid), 32'd1);
    tick();
    chk("wa_read_done", 32'(busy), 32'd0);

    // m1 read arrives during m0's write and waits for the write response
    m0_if.awaddr = 32'h0800; m0_if.awlen = 8'd1; m0_if.awvalid = 1'b1;
    tick();
    m0_if.awvalid = 1'b0;
    m1_if.araddr = 32'h0900; m1_if.arlen = 8'd0; m1_if.arvalid = 1'b1;
    m0_if.wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("blk_data_m1_arready", 32'(m1_if.arready), 32'd0);
      chk("blk_data_grant", 32'(grant_id), 32'd0);
      tick();
    end
    m0_if.wvalid = 1'b0;
    #1;
    chk("blk_resp_m1_arready", 32'(m1_if.arready), 32'd0);
    chk("blk_resp_busy", 32'(busy), 32'd1);
    tick();
    s_if.bvalid = 1'b1;
    #1;
    chk("blk_resp2_m1_arready", 32'(m1_if.arready), 32'd0);
    tick();
    s_if.bvalid = 1'b0;
    #1;
    chk("blk_idle_m1_arready", 32'(m1_if.arready), 32'd1);
    chk("blk_idle_araddr", s_if.araddr, 32'h0900);
    tick();
    m1_if.arvalid = 1'b0;
    chk("blk_grant", 32'(grant_id), 32'd1);
    chk("blk_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    tick();
    chk("blk_done", 32'(busy), 32'd0);

    // reset during a 4-beat read after two beats, then a fresh 2-beat read
    m0_if.araddr = 32'h0A00; m0_if.arlen = 8'd3; m0_if.arvalid = 1'b1;
    tick();
    m0_if.arvalid = 1'b0;
    tick();
    tick();
    chk("mid_busy_before", 32'(busy), 32'd1);
    m0_if.arvalid = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("mid_rst_s_rready", 32'(s_if.rready), 32'd0);
    chk("mid_rst_s_arvalid", 32'(s_if.arvalid), 32'd0);
    m0_if.arvalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    m1_if.araddr = 32'h0B00; m1_if.arlen = 8'd1; m1_if.arvalid = 1'b1;
    #1;
    chk("post_rst_m1_arready", 32'(m1_if.arready), 32'd1);
    tick();
    m1_if.arvalid = 1'b0;
    chk("post_rst_grant", 32'(grant_id), 32'd1);
    tick();
    chk("post_rst_beat1_busy", 32'(busy), 32'd1);
    tick();
    chk("post_rst_beat2_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
